fpga_exit_reporter: RTL and testbench
=====================================

FPGA_EXIT_REPORTER -- requirements
Module: fpga_exit_reporter

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 15000000: frequency of clk_gen in Hz.
REQ-002 Parameter BAUD_RATE, default 115200: UART bit rate; DIV = CLK_FREQ_HZ / BAUD_RATE, integer truncation, DIV >= 2 (elaboration error otherwise).
REQ-003 Parameter BLINK_LOG2, default 23: fail-LED blink half-period is 2^BLINK_LOG2 cycles.
REQ-004 The reset is rst_n, asynchronous, active-low; the clock is clk_gen.
REQ-005 clk_gen  input  1  system clock shared with x_heep_system; all logic on rising edge.
REQ-006 rst_n  input  1  async active-low reset.
REQ-007 exit_valid_i  input  1  program-exit flag from the MCU, same clock domain.
REQ-008 exit_value_i  input  32  program exit code from the MCU.
REQ-009 tx_o  output  1  report UART line, 8N1, idle high.
REQ-010 busy_o  output  1  high while a report is being transmitted.
REQ-011 done_o  output  1  one-cycle pulse when the report's last stop bit completes.
REQ-012 pass_led_o  output  1  exit code was zero.
REQ-013 fail_led_o  output  1  exit code was non-zero.

Function
REQ-014 Trigger: clock edge where exit_valid_i=1 and registered previous value=0 while in IDLE; exit_value_i captured on that edge.
REQ-015 Trigger edges while busy_o=1 are ignored; exit_valid_i held high never re-triggers; a new report requires a low-then-high transition.
REQ-016 Message, fixed 15 bytes in order: "EXIT=" then the captured value as 8 uppercase ASCII hex digits, MSB nibble first, then 0x0D, 0x0A.
REQ-017 FSM states: IDLE, START, DATA, STOP, DONE.
REQ-018 IDLE -> START on trigger; on that same edge tx_o goes 0 and busy_o goes 1.
REQ-019 Every bit lasts exactly DIV cycles, timed by a baud counter reloaded at each bit boundary.
REQ-020 START -> DATA after DIV cycles; DATA sends 8 bits LSB first, then -> STOP; STOP drives 1 for DIV cycles.
REQ-021 After STOP: byte index < 14 -> START of next byte with no idle gap; byte index = 14 -> DONE.
REQ-022 DONE lasts one cycle with done_o=1, busy_o=0, tx_o=1, then -> IDLE.
REQ-023 Total report length: 150*DIV cycles from trigger edge to done_o assertion edge.
REQ-024 The captured value is held constant during transmission regardless of exit_value_i changes.
REQ-025 Hex nibble to ASCII: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.

Reset
REQ-026 Asserting rst_n at any time, including mid-byte, returns the FSM to IDLE immediately: tx_o=1, busy_o=0, done_o=0, pass_led_o=0, fail_led_o=0, counters and captured value cleared.
REQ-027 After reset release, exit_valid_i already high does not trigger until it goes low then high, because the previous-value register resets to 1.

Configuration
REQ-028 Macro FPGA_EXIT_REPORTER_LED_EN. When defined, on trigger pass_led_o=(value==0) and fail_led_o toggles every 2^BLINK_LOG2 cycles when value!=0; both hold until reset or the next trigger.
REQ-029 Without FPGA_EXIT_REPORTER_LED_EN, pass_led_o and fail_led_o are tied 0, no blink counter exists, and UART behaviour is unchanged.

Verification
REQ-030 CLK_FREQ_HZ=1000, BAUD_RATE=100, value 0x0000002A -> bytes 45 58 49 54 3D 30 30 30 30 30 30 32 41 0D 0A on tx_o; each bit 10 cycles; done_o 1500 cycles after the trigger edge.
REQ-031 Value 0xDEADBEEF -> hex bytes 44 45 41 44 42 45 45 46; exit_value_i changed to 0 mid-report -> transmitted digits unchanged.
REQ-032 exit_valid_i pulsed low/high again at cycle 300 of a report -> ignored, exactly 15 bytes sent; pulse after done_o -> second full report.
REQ-033 rst_n asserted at cycle 437 of a report -> tx_o=1 and busy_o=0 immediately; exit_valid_i held high through release -> no new report.
REQ-034 LED_EN defined, BLINK_LOG2=3, value 0 -> pass_led_o=1, fail_led_o=0; value 5 -> pass_led_o=0, fail_led_o toggles every 8 cycles; LED_EN undefined -> both LEDs stay 0.

Source files
------------

// File: rtl/fpga_exit_reporter.sv
// Sends "EXIT=XXXXXXXX\r\n" over an 8N1 UART when the MCU raises its exit flag.
// Optional pass/fail LEDs are built only when FPGA_EXIT_REPORTER_LED_EN is defined.
module fpga_exit_reporter #(
    parameter int CLK_FREQ_HZ = 15000000,
    parameter int BAUD_RATE   = 115200,
    parameter int BLINK_LOG2  = 23
) (
    input  logic        clk_gen,
    input  logic        rst_n,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_led_o,
    output logic        fail_led_o
);

    localparam int DIV   = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);

    if (DIV < 2 || BLINK_LOG2 < 1) begin : g_bad_cfg
        $error("fpga_exit_reporter: CLK_FREQ_HZ/BAUD_RATE must be >= 2 and BLINK_LOG2 >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_valid_prev;
    logic [31:0]      r_value;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [3:0]       r_byte_idx;

    logic             w_trigger;
    logic             w_start;
    logic             w_baud_tick;
    logic [2:0]       w_nib_sel;
    logic [3:0]       w_nibble;
    logic [7:0]       w_hex;
    logic [7:0]       w_byte;

    // Previous-value register resets high so a flag already set at release is not a trigger.
    assign w_trigger   = exit_valid_i & ~r_valid_prev;
    assign w_start     = (r_state == S_IDLE) && w_trigger;
    assign w_baud_tick = (r_baud_cnt == '0);

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_trigger) w_next_state = S_START;
            S_START: if (w_baud_tick) w_next_state = S_DATA;
            S_DATA:  if (w_baud_tick && r_bit_idx == 3'd7) w_next_state = S_STOP;
            S_STOP:  if (w_baud_tick) w_next_state = (r_byte_idx == 4'd14) ? S_DONE : S_START;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        tx_o   = 1'b1;
        busy_o = 1'b0;
        done_o = 1'b0;
        case (r_state)
            S_START: begin
                tx_o   = 1'b0;
                busy_o = 1'b1;
            end
            S_DATA: begin
                tx_o   = w_byte[r_bit_idx];
                busy_o = 1'b1;
            end
            S_STOP: busy_o = 1'b1;
            S_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_prev <= 1'b1;
            r_value      <= '0;
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_byte_idx   <= '0;
        end else begin
            r_valid_prev <= exit_valid_i;
            if (w_start) begin
                r_value    <= exit_value_i;
                r_baud_cnt <= DIV_M1;
                r_bit_idx  <= '0;
                r_byte_idx <= '0;
            end else if (r_state == S_START || r_state == S_DATA || r_state == S_STOP) begin
                if (w_baud_tick) begin
                    r_baud_cnt <= DIV_M1;
                    if (r_state == S_DATA) r_bit_idx <= r_bit_idx + 3'd1;
                    if (r_state == S_STOP) r_byte_idx <= r_byte_idx + 4'd1;
                end else begin
                    r_baud_cnt <= r_baud_cnt - CNT_W'(1);
                end
            end
        end
    end

    // Bytes 5..12 carry nibbles 7..0 of the captured value.
    assign w_nib_sel = 3'(4'd12 - r_byte_idx);
    assign w_nibble  = r_value[{w_nib_sel, 2'b00} +: 4];
    assign w_hex     = (w_nibble < 4'd10) ? (8'h30 + {4'h0, w_nibble}) : (8'h37 + {4'h0, w_nibble});

    always_comb begin
        w_byte = 8'h0A;
        case (r_byte_idx)
            4'd0:  w_byte = 8'h45;
            4'd1:  w_byte = 8'h58;
            4'd2:  w_byte = 8'h49;
            4'd3:  w_byte = 8'h54;
            4'd4:  w_byte = 8'h3D;
            4'd13: w_byte = 8'h0D;
            4'd14: w_byte = 8'h0A;
            default: w_byte = w_hex;
        endcase
    end

`ifdef FPGA_EXIT_REPORTER_LED_EN
    logic                  r_pass_led;
    logic                  r_fail_led;
    logic                  r_blink_en;
    logic [BLINK_LOG2-1:0] r_blink_cnt;

    // Fail LED lights on the trigger edge, then flips each time the blink counter wraps.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            r_pass_led  <= 1'b0;
            r_fail_led  <= 1'b0;
            r_blink_en  <= 1'b0;
            r_blink_cnt <= '0;
        end else if (w_start) begin
            r_pass_led  <= (exit_value_i == 32'd0);
            r_fail_led  <= (exit_value_i != 32'd0);
            r_blink_en  <= (exit_value_i != 32'd0);
            r_blink_cnt <= '0;
        end else if (r_blink_en) begin
            r_blink_cnt <= r_blink_cnt + BLINK_LOG2'(1);
            if (&r_blink_cnt) r_fail_led <= ~r_fail_led;
        end
    end

    assign pass_led_o = r_pass_led;
    assign fail_led_o = r_fail_led;
`else
    assign pass_led_o = 1'b0;
    assign fail_led_o = 1'b0;
`endif

endmodule

// File: tb/tb_fpga_exit_reporter.sv
// Directed bench for fpga_exit_reporter at DIV=10: decodes the UART stream
// mid-bit and checks bytes, framing, done timing, re-trigger and reset behaviour.
module tb_fpga_exit_reporter;

    logic        clk_gen = 1'b0;
    logic        rst_n;
    logic        exit_valid_i;
    logic [31:0] exit_value_i;
    logic        tx_o;
    logic        busy_o;
    logic        done_o;
    logic        pass_led_o;
    logic        fail_led_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_gen = ~clk_gen;

    fpga_exit_reporter #(
        .CLK_FREQ_HZ(1000),
        .BAUD_RATE  (100),
        .BLINK_LOG2 (3)
    ) dut (
        .clk_gen     (clk_gen),
        .rst_n       (rst_n),
        .exit_valid_i(exit_valid_i),
        .exit_value_i(exit_value_i),
        .tx_o        (tx_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_led_o  (pass_led_o),
        .fail_led_o  (fail_led_o)
    );

    task automatic tick();
        @(posedge clk_gen);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_pass_led(input logic [31:0] v);
`ifdef FPGA_EXIT_REPORTER_LED_EN
        return (v == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    // c = cycles after the trigger edge; the LED flips every 8 cycles.
    function automatic logic exp_fail_led(input logic [31:0] v, input int c);
`ifdef FPGA_EXIT_REPORTER_LED_EN
        return (v != 32'd0) && (((c / 8) % 2) == 0);
`else
        return 1'b0;
`endif
    endfunction

    // action: 0 plain, 1 change exit_value_i mid-report, 2 re-pulse exit_valid_i at cycle 300,
    // 3 assert reset at cycle 437 and return with reset still asserted.
    task automatic run_report(input logic [31:0] val, input logic [119:0] exp_bytes, input int action);
        int k, j, b, quiet;
        logic [7:0] rx;
        logic start_b;
        rx = '0;
        start_b = 1'b1;
        exit_valid_i = 1'b0;
        tick();
        exit_valid_i = 1'b1;
        exit_value_i = val;
        tick();
        chk("trig_tx", tx_o, 1'b0);
        chk("trig_busy", busy_o, 1'b1);
        chk("pass_led", pass_led_o, exp_pass_led(val));
        chk("fail_led_c0", fail_led_o, exp_fail_led(val, 0));
        for (int c = 1; c <= 1501; c++) begin
            tick();
            if (action == 1 && c == 100) exit_value_i = 32'd0;
            if (action == 2 && c == 300) exit_valid_i = 1'b0;
            if (action == 2 && c == 301) exit_valid_i = 1'b1;
            if (action == 3 && c == 437) begin
                rst_n = 1'b0;
                #1;
                chk("rst_tx", tx_o, 1'b1);
                chk("rst_busy", busy_o, 1'b0);
                chk("rst_done", done_o, 1'b0);
                chk("rst_pass", pass_led_o, 1'b0);
                chk("rst_fail", fail_led_o, 1'b0);
                return;
            end
            if (c <= 1500 && (c % 10) == 5) begin
                k = c / 10;
                j = k % 10;
                b = k / 10;
                if (j == 0) start_b = tx_o;
                else if (j <= 8) rx[j-1] = tx_o;
                else begin
                    chk($sformatf("frame%0d", b), {start_b, tx_o}, 2'b01);
                    chk($sformatf("byte%0d", b), rx, exp_bytes[119 - 8*b -: 8]);
                end
            end
            if (c == 7 || c == 8 || c == 16)
                chk($sformatf("fail_led_c%0d", c), fail_led_o, exp_fail_led(val, c));
            if (c == 1499) begin
                chk("pre_done_busy", busy_o, 1'b1);
                chk("pre_done_done", done_o, 1'b0);
            end
            if (c == 1500) begin
                chk("done_pulse", done_o, 1'b1);
                chk("done_busy", busy_o, 1'b0);
                chk("done_tx", tx_o, 1'b1);
            end
            if (c == 1501) chk("done_one_cycle", done_o, 1'b0);
        end
        quiet = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (busy_o || !tx_o || done_o) quiet++;
        end
        chk("idle_after_done", quiet, 0);
    endtask

    initial begin
        logic [119:0] e_2a, e_dead, e_5, e_0;
        int act;
        e_2a   = {8'h45, 8'h58, 8'h49, 8'h54, 8'h3D, 8'h30, 8'h30, 8'h30,
                  8'h30, 8'h30, 8'h30, 8'h32, 8'h41, 8'h0D, 8'h0A};
        e_dead = {8'h45, 8'h58, 8'h49, 8'h54, 8'h3D, 8'h44, 8'h45, 8'h41,
                  8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        e_5    = {8'h45, 8'h58, 8'h49, 8'h54, 8'h3D, 8'h30, 8'h30, 8'h30,
                  8'h30, 8'h30, 8'h30, 8'h30, 8'h35, 8'h0D, 8'h0A};
        e_0    = {8'h45, 8'h58, 8'h49, 8'h54, 8'h3D, 8'h30, 8'h30, 8'h30,
                  8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};

        rst_n = 1'b0;
        exit_valid_i = 1'b0;
        exit_value_i = 32'd0;
        repeat (3) tick();
        chk("reset_tx", tx_o, 1'b1);
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_done", done_o, 1'b0);
        chk("reset_pass", pass_led_o, 1'b0);
        chk("reset_fail", fail_led_o, 1'b0);
        rst_n = 1'b1;
        tick();

        run_report(32'h0000002A, e_2a, 0);
        run_report(32'hDEADBEEF, e_dead, 1);
        run_report(32'h0000002A, e_2a, 2);
        run_report(32'h00000005, e_5, 0);
        run_report(32'h0000002A, e_2a, 3);

        // Release reset with the exit flag still high: no report may start.
        repeat (2) tick();
        rst_n = 1'b1;
        act = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (busy_o || !tx_o || done_o) act++;
        end
        chk("no_retrigger_after_reset", act, 0);

        run_report(32'h00000000, e_0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
